// File: rtl/tribus_drive_ctrl_if.sv
// Request/grant and tri-state driver pin bundle between requesters and tribus_drive_ctrl.
// The master side is the requester pool; the slave side is the controller that drives EN/I.
interface tribus_drive_ctrl_if #(
   parameter int N = 4,
   parameter int W = 8
);
   logic [N-1:0]   REQ;
   logic [N*W-1:0] DIN;
   logic [N-1:0]   GNT;
   logic [N-1:0]   EN;
   logic [N*W-1:0] I;
   logic           BUSY;

   modport master (output REQ, DIN, input GNT, EN, I, BUSY);
   modport slave  (input REQ, DIN, output GNT, EN, I, BUSY);
endinterface

// File: rtl/tribus_drive_ctrl.sv
// Round-robin owner of a shared bufz bus with break-before-make dead time between grants.
// Outputs registered; grant 1 cycle after REQ in IDLE; REQ ignored while DRIVE/DEAD.
module tribus_drive_ctrl #(
   parameter int N        = 4,
   parameter int W        = 8,
   parameter int DEAD_CYC = 2,
   parameter int MAX_HOLD = 4
) (
   input  logic               CLK,
   input  logic               RN,
   tribus_drive_ctrl_if.slave bus
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int HW = $clog2(MAX_HOLD + 2);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
   localparam logic [3:0]    DEAD_INIT = 4'(DEAD_CYC);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRIVE = 2'd1, S_DEAD = 2'd2} state_t;

   state_t         state_q, state_d;
   logic [PW-1:0]  owner_q, owner_d;
   logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]  winner;
   logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
   logic [3:0]     dead_cnt_q, dead_cnt_d;
   logic [N-1:0]   gnt_q, gnt_d;
   logic [N*W-1:0] i_q, i_d;
   logic           any_req;
   logic           others_req;
   logic           release_bus;

   always_ff @(posedge CLK) begin
      if (!RN) begin
         state_q    <= S_IDLE;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         hold_cnt_q <= '0;
         dead_cnt_q <= '0;
         gnt_q      <= '0;
         i_q        <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         hold_cnt_q <= hold_cnt_d;
         dead_cnt_q <= dead_cnt_d;
         gnt_q      <= gnt_d;
         i_q        <= i_d;
      end
   end

   // First requester at or above rr_ptr, wrapping past N-1 back to 0.
   always_comb begin
      int idx;
      any_req = 1'b0;
      winner  = '0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= N) idx = idx - N;
         if (!any_req && bus.REQ[idx]) begin
            any_req = 1'b1;
            winner  = PW'(idx);
         end
      end
   end

   assign others_req  = |(bus.REQ & ~(N'(1) << owner_q));
   assign release_bus = !bus.REQ[owner_q] ||
                        ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_MAX) && others_req);

   always_comb begin
      state_d    = state_q;
      dead_cnt_d = dead_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (any_req) state_d = S_DRIVE;
         end
         S_DRIVE: begin
            if (release_bus) begin
               if (DEAD_CYC == 0) begin
                  state_d = S_IDLE;
               end else begin
                  state_d    = S_DEAD;
                  dead_cnt_d = DEAD_INIT;
               end
            end
         end
         S_DEAD: begin
            dead_cnt_d = dead_cnt_q - 4'd1;
            if (dead_cnt_q == 4'd1) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Only the owning group ever sees a non-zero EN or I; everything else is forced low.
   always_comb begin
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      hold_cnt_d = hold_cnt_q;
      gnt_d      = '0;
      i_d        = '0;
      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               owner_d                = winner;
               hold_cnt_d             = HW'(1);
               gnt_d[winner]          = 1'b1;
               i_d[winner*W +: W]     = bus.DIN[winner*W +: W];
            end
         end
         S_DRIVE: begin
            if (release_bus) begin
               rr_ptr_d = (owner_q == PW'(N - 1)) ? '0 : owner_q + 1'b1;
            end else begin
               gnt_d[owner_q]         = 1'b1;
               i_d[owner_q*W +: W]    = bus.DIN[owner_q*W +: W];
               if ((MAX_HOLD != 0) && (hold_cnt_q != HOLD_MAX))
                  hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign bus.GNT  = gnt_q;
   assign bus.EN   = gnt_q;
   assign bus.I    = i_q;
   assign bus.BUSY = (state_q != S_IDLE);
endmodule

// File: tb/tb_tribus_drive_ctrl.sv
// Directed bench for tribus_drive_ctrl with N=4, W=8, DEAD_CYC=2, MAX_HOLD=4.
// Scenario tasks run in sequence; a negedge monitor checks the bus-safety invariants each cycle.
module tb_tribus_drive_ctrl;
   localparam int N = 4;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rn  = 1'b0;
   int   total = 0;
   int   bad   = 0;
   bit   chk_en = 1'b0;

   always #5 clk = ~clk;

   tribus_drive_ctrl_if #(.N(N), .W(W)) bus ();

   tribus_drive_ctrl #(.N(N), .W(W), .DEAD_CYC(2), .MAX_HOLD(4)) dut (
      .CLK (clk),
      .RN  (rn),
      .bus (bus)
   );

   always @(negedge clk) begin
      if (chk_en) begin
         total++;
         if (($countones(bus.EN) > 1) || (bus.EN !== bus.GNT)) begin
            bad++;
            $display("FAIL inv_en: EN=%b GNT=%b, need one-hot-or-zero and EN==GNT", bus.EN, bus.GNT);
         end
         for (int k = 0; k < N; k++) begin
            if (!bus.GNT[k]) begin
               total++;
               if (bus.I[k*W +: W] !== 8'h00) begin
                  bad++;
                  $display("FAIL inv_i%0d: I group=%h while not granted, need 00", k, bus.I[k*W +: W]);
               end
            end
         end
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rn      = 1'b0;
      bus.REQ = '0;
      bus.DIN = '0;
      step;
      step;
      rn = 1'b1;
   endtask

   function automatic int oh2idx(input logic [3:0] v);
      for (int k = 0; k < 4; k++) if (v[k]) return k;
      return -1;
   endfunction

   task automatic run_len(input logic [3:0] v, output int n);
      n = 0;
      while (bus.EN === v && n < 50) begin
         n++;
         step;
      end
   endtask

   task automatic wait_grant(output logic [3:0] g);
      int c;
      c = 0;
      while (bus.EN === 4'b0000 && c < 30) begin
         step;
         c++;
      end
      g = bus.EN;
   endtask

   task automatic test_reset;
      rn      = 1'b0;
      bus.REQ = 4'b1111;
      bus.DIN = 32'hFFFF_FFFF;
      step;
      step;
      total++; if (bus.GNT !== 4'b0000) begin bad++; $display("FAIL rst_gnt: got %b need 0000", bus.GNT); end
      total++; if (bus.EN !== 4'b0000) begin bad++; $display("FAIL rst_en: got %b need 0000", bus.EN); end
      total++; if (bus.I !== 32'h0) begin bad++; $display("FAIL rst_i: got %h need 0", bus.I); end
      total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b need 0", bus.BUSY); end
      bus.REQ = '0;
      bus.DIN = '0;
      rn      = 1'b1;
   endtask

   task automatic test_single;
      do_reset;
      bus.REQ = 4'b0010;
      bus.DIN = 32'h4433_A522;
      step;
      total++; if (bus.GNT !== 4'b0010) begin bad++; $display("FAIL single_gnt: got %b need 0010", bus.GNT); end
      total++; if (bus.EN !== 4'b0010) begin bad++; $display("FAIL single_en: got %b need 0010", bus.EN); end
      total++; if (bus.I !== 32'h0000_A500) begin bad++; $display("FAIL single_i: got %h need 0000a500", bus.I); end
      total++; if (bus.BUSY !== 1'b1) begin bad++; $display("FAIL single_busy: got %b need 1", bus.BUSY); end
      bus.DIN = 32'h4433_5A22;
      step;
      total++; if (bus.I !== 32'h0000_5A00) begin bad++; $display("FAIL single_din: got %h need 00005a00", bus.I); end
   endtask

   task automatic test_release;
      bus.REQ = 4'b0100;
      for (int c = 0; c < 3; c++) begin
         step;
         total++;
         if (bus.EN !== 4'b0000) begin bad++; $display("FAIL gap_c%0d: EN=%b need 0000", c, bus.EN); end
      end
      total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL gap_idle_busy: got %b need 0", bus.BUSY); end
      step;
      total++; if (bus.EN !== 4'b0100) begin bad++; $display("FAIL regrant_en: got %b need 0100", bus.EN); end
      total++; if (bus.I !== 32'h0033_0000) begin bad++; $display("FAIL regrant_i: got %h need 00330000", bus.I); end
   endtask

   task automatic test_round_robin;
      int got [5];
      int expv [5];
      int n;
      int cyc;
      expv = '{0, 1, 3, 0, 1};
      got  = '{-1, -1, -1, -1, -1};
      n    = 0;
      cyc  = 0;
      do_reset;
      bus.REQ = 4'b1011;
      while (n < 5 && cyc < 200) begin
         step;
         cyc++;
         if (bus.EN !== 4'b0000) begin
            got[n]  = oh2idx(bus.EN);
            n++;
            bus.REQ = 4'b1011 & ~bus.EN;
         end else begin
            bus.REQ = 4'b1011;
         end
      end
      total++; if (n != 5) begin bad++; $display("FAIL rr_count: got %0d grants need 5", n); end
      for (int k = 0; k < 5; k++) begin
         total++;
         if (got[k] != expv[k]) begin bad++; $display("FAIL rr_order%0d: owner %0d need %0d", k, got[k], expv[k]); end
      end
      bus.REQ = '0;
   endtask

   task automatic test_preempt;
      logic [3:0] cur;
      int n;
      do_reset;
      bus.REQ = 4'b0011;
      step;
      total++; if (bus.EN !== 4'b0001) begin bad++; $display("FAIL pre_first: EN=%b need 0001", bus.EN); end
      cur = 4'b0001;
      for (int r = 0; r < 3; r++) begin
         run_len(cur, n);
         total++; if (n != 4) begin bad++; $display("FAIL pre_hold%0d: held %0d cycles need 4", r, n); end
         run_len(4'b0000, n);
         total++; if (n != 3) begin bad++; $display("FAIL pre_gap%0d: gap %0d cycles need 3", r, n); end
         cur = (cur == 4'b0001) ? 4'b0010 : 4'b0001;
         total++; if (bus.EN !== cur) begin bad++; $display("FAIL pre_next%0d: EN=%b need %b", r, bus.EN, cur); end
      end
      bus.REQ = '0;
   endtask

   task automatic test_sole_owner;
      int en_ok;
      int i_ok;
      en_ok = 0;
      i_ok  = 0;
      do_reset;
      bus.REQ = 4'b1000;
      step;
      for (int c = 0; c < 20; c++) begin
         if (bus.EN === 4'b1000) en_ok++;
         bus.DIN = {8'(c + 1), 24'hABCDEF};
         step;
         if (bus.I === {8'(c + 1), 24'h000000}) i_ok++;
      end
      total++; if (en_ok != 20) begin bad++; $display("FAIL sole_en: %0d of 20 cycles granted need 20", en_ok); end
      total++; if (i_ok != 20) begin bad++; $display("FAIL sole_i: %0d of 20 cycles correct need 20", i_ok); end
      bus.REQ = '0;
   endtask

   task automatic test_reset_mid;
      logic [3:0] g;
      do_reset;
      bus.DIN = 32'hFFFF_FFFF;
      bus.REQ = 4'b0010;
      step;
      bus.REQ = 4'b0001;
      step;
      wait_grant(g);
      total++; if (g !== 4'b0001) begin bad++; $display("FAIL mid_pre: EN=%b need 0001", g); end
      rn = 1'b0;
      step;
      total++; if (bus.EN !== 4'b0000) begin bad++; $display("FAIL mid_en: got %b need 0000", bus.EN); end
      total++; if (bus.GNT !== 4'b0000) begin bad++; $display("FAIL mid_gnt: got %b need 0000", bus.GNT); end
      total++; if (bus.I !== 32'h0) begin bad++; $display("FAIL mid_i: got %h need 0", bus.I); end
      rn = 1'b1;
      step;
      total++; if (bus.EN !== 4'b0001) begin bad++; $display("FAIL mid_regrant: got %b need 0001", bus.EN); end
      // Push rr_ptr to 2, reset while in DEAD, and confirm arbitration restarts from 0.
      bus.REQ = 4'b0010;
      step;
      wait_grant(g);
      total++; if (g !== 4'b0010) begin bad++; $display("FAIL mid_g1: EN=%b need 0010", g); end
      bus.REQ = 4'b0000;
      step;
      step;
      rn = 1'b0;
      step;
      rn      = 1'b1;
      bus.REQ = 4'b0110;
      step;
      total++; if (bus.EN !== 4'b0010) begin bad++; $display("FAIL mid_rrptr: got %b need 0010", bus.EN); end
      bus.REQ = '0;
   endtask

   initial begin
      bus.REQ = '0;
      bus.DIN = '0;
      do_reset;
      chk_en = 1'b1;
      test_reset;
      test_single;
      test_release;
      test_round_robin;
      test_preempt;
      test_sole_owner;
      test_reset_mid;
      step;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
